// File: rtl/score_display.sv
// Four-digit multiplexed 7-segment driver: high score on digits 3-2, current score on 1-0.
// Binary-to-BCD conversion is a sequential shift-add-3 FSM; the score digits blink during a collision.
module score_display #(
    parameter int W          = 6,
    parameter int SCAN_BITS  = 18,
    parameter int BLINK_BITS = 25
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [W-1:0] score,
    input  logic         colision,
    output logic [3:0]   an,
    output logic [7:0]   sseg,
    output logic         busy
);

    // state | meaning
    // IDLE  | waiting for score or hi_reg to differ from the last converted pair
    // SHIFT | W adjust-and-shift steps on both BCD shift registers
    // DONE  | copy finished BCD digits into the display registers
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int SW = W + 8;
    localparam int CW = (W > 1) ? $clog2(W) : 1;

    state_t          state;
    logic [CW-1:0]   cnt;
    logic [W-1:0]    last_s, last_h, hi_reg;
    logic [SW-1:0]   sh_s, sh_h;
    logic [3:0]      disp_s0, disp_s1, disp_h0, disp_h1;
    logic            colision_d;
    logic [SCAN_BITS-1:0]  scan_cnt;
    logic [BLINK_BITS-1:0] blink_cnt;
    logic [1:0]      sel;
    logic [3:0]      digit;
    logic [3:0]      an_next;

    function automatic logic [SW-1:0] dabble(input logic [SW-1:0] v);
        logic [SW-1:0] t;
        t = v;
        if (t[W+3:W] >= 4'd5)   t[W+3:W]   = t[W+3:W] + 4'd3;
        if (t[W+7:W+4] >= 4'd5) t[W+7:W+4] = t[W+7:W+4] + 4'd3;
        return {t[SW-2:0], 1'b0};
    endfunction

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            last_s  <= '0;
            last_h  <= '0;
            sh_s    <= '0;
            sh_h    <= '0;
            disp_s0 <= '0;
            disp_s1 <= '0;
            disp_h0 <= '0;
            disp_h1 <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Changes seen mid-conversion are picked up here, so the display always converges
                    if ({score, hi_reg} != {last_s, last_h}) begin
                        last_s <= score;
                        last_h <= hi_reg;
                        sh_s   <= {8'd0, score};
                        sh_h   <= {8'd0, hi_reg};
                        cnt    <= '0;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    sh_s <= dabble(sh_s);
                    sh_h <= dabble(sh_h);
                    cnt  <= cnt + CW'(1);
                    if (cnt == CW'(W - 1)) state <= DONE;
                end
                DONE: begin
                    disp_s0 <= sh_s[W+3:W];
                    disp_s1 <= sh_s[W+7:W+4];
                    disp_h0 <= sh_h[W+3:W];
                    disp_h1 <= sh_h[W+7:W+4];
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign sel  = scan_cnt[SCAN_BITS-1 -: 2];

    always_comb begin
        digit = disp_s0;
        case (sel)
            2'd0: digit = disp_s0;
            2'd1: digit = disp_s1;
            2'd2: digit = disp_h0;
            2'd3: digit = disp_h1;
            default: digit = disp_s0;
        endcase
        an_next = ~(4'b0001 << sel);
        if (colision && blink_cnt[BLINK_BITS-1] && !sel[1]) an_next = 4'b1111;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            colision_d <= 1'b0;
            hi_reg     <= '0;
            scan_cnt   <= '0;
            blink_cnt  <= '0;
            an         <= 4'b1111;
            sseg       <= 8'hFF;
        end else begin
            colision_d <= colision;
            if (colision && !colision_d && score > hi_reg) hi_reg <= score;
            scan_cnt  <= scan_cnt + 1'b1;
            blink_cnt <= blink_cnt + 1'b1;
            an        <= an_next;
            // dp lit only on digit 2 to form "hh.ss"
            sseg      <= {(sel != 2'd2), seg7(digit)};
        end
    end

endmodule

// File: tb/tb_score_display.sv
// Self-checking bench for score_display with short scan/blink counters.
module tb_score_display;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] score = '0;
    logic         colision = 1'b0;
    logic [3:0]   an;
    logic [7:0]   sseg;
    logic         busy;

    int checks = 0;
    int errors = 0;

    score_display #(.W(W), .SCAN_BITS(4), .BLINK_BITS(5)) dut (
        .clk(clk), .reset(reset), .score(score), .colision(colision),
        .an(an), .sseg(sseg), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [6:0] seg_code(input int d);
        logic [6:0] s;
        case (d)
            0: s = 7'b1000000;
            1: s = 7'b1111001;
            2: s = 7'b0100100;
            3: s = 7'b0110000;
            4: s = 7'b0011001;
            5: s = 7'b0010010;
            6: s = 7'b0000010;
            7: s = 7'b1111000;
            8: s = 7'b0000000;
            9: s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    // Scan scoreboard: expected enables/dp pushed at each edge, compared at the next negedge
    typedef struct packed {
        logic [3:0] an;
        logic       dp;
    } exp_t;
    exp_t sb[$];
    logic [3:0] scan_m = '0;
    logic [4:0] blink_m = '0;

    always @(posedge clk) begin
        exp_t e;
        logic [1:0] s;
        if (!reset) begin
            scan_m  <= '0;
            blink_m <= '0;
            e.an = 4'b1111;
            e.dp = 1'b1;
        end else begin
            s = scan_m[3:2];
            e.an = ~(4'b0001 << s);
            if (colision && blink_m[4] && !s[1]) e.an = 4'b1111;
            e.dp = (s != 2'd2);
            scan_m  <= scan_m + 1'b1;
            blink_m <= blink_m + 1'b1;
        end
        sb.push_back(e);
    end

    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            checks++;
            if (an !== e.an || sseg[7] !== e.dp) begin
                errors++;
                $display("FAIL scan: an=%b dp=%b expected an=%b dp=%b at %0t", an, sseg[7], e.an, e.dp, $time);
            end
        end
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_digits(input int d3, input int d2, input int d1, input int d0);
        logic [3:0] seen;
        seen = '0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            case (an)
                4'b1110: begin check("digit0", {1'b0, sseg[6:0]}, {1'b0, seg_code(d0)}); seen[0] = 1'b1; end
                4'b1101: begin check("digit1", {1'b0, sseg[6:0]}, {1'b0, seg_code(d1)}); seen[1] = 1'b1; end
                4'b1011: begin check("digit2", {1'b0, sseg[6:0]}, {1'b0, seg_code(d2)}); seen[2] = 1'b1; end
                4'b0111: begin check("digit3", {1'b0, sseg[6:0]}, {1'b0, seg_code(d3)}); seen[3] = 1'b1; end
                default: ;
            endcase
        end
        check("digits_seen", {4'b0, seen}, 8'h0F);
    endtask

    task automatic settle();
        int zeros;
        int n;
        zeros = 0;
        n = 0;
        while (zeros < 3 && n < 200) begin
            @(negedge clk);
            zeros = busy ? 0 : zeros + 1;
            n++;
        end
        checks++;
        if (zeros < 3) begin
            errors++;
            $display("FAIL settle: busy still %b after %0d cycles expected 0", busy, n);
        end
    endtask

    typedef struct {
        logic [W-1:0] score;
        logic         col;
        int           d3, d2, d1, d0;
    } vec_t;

    vec_t vecs[6];
    int blanks;

    initial begin
        vecs[0] = '{6'd63, 1'b0, 0, 0, 6, 3};
        vecs[1] = '{6'd20, 1'b1, 2, 0, 2, 0};
        vecs[2] = '{6'd37, 1'b1, 3, 7, 3, 7};
        vecs[3] = '{6'd12, 1'b1, 3, 7, 1, 2};
        vecs[4] = '{6'd37, 1'b1, 3, 7, 3, 7};
        vecs[5] = '{6'd5,  1'b0, 3, 7, 0, 5};

        // Reset state
        reset = 1'b0;
        repeat (2) @(negedge clk);
        check("reset_an", {4'b0, an}, 8'h0F);
        check("reset_sseg", sseg, 8'hFF);
        check("reset_busy", {7'b0, busy}, 8'h00);
        score = 0;
        reset = 1'b1;
        check_digits(0, 0, 0, 0);

        // Conversion latency: busy for edges k..k+6, display settled at k+7
        score = 6'd45;
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("busy_conv", {7'b0, busy}, 8'h01);
        end
        @(negedge clk);
        check("busy_done", {7'b0, busy}, 8'h00);
        check_digits(0, 0, 4, 5);

        // Table of score / collision patterns
        for (int v = 0; v < 6; v++) begin
            score = vecs[v].score;
            colision = vecs[v].col;
            settle();
            colision = 1'b0;
            check_digits(vecs[v].d3, vecs[v].d2, vecs[v].d1, vecs[v].d0);
        end

        // Score changes mid-SHIFT: first conversion finishes, then re-converts
        score = 6'd63;
        repeat (3) @(negedge clk);
        score = 6'd10;
        repeat (4) @(negedge clk);
        check("busy_first_conv", {7'b0, busy}, 8'h01);
        @(negedge clk);
        check("busy_gap", {7'b0, busy}, 8'h00);
        @(negedge clk);
        check("busy_reconvert", {7'b0, busy}, 8'h01);
        settle();
        check_digits(3, 7, 1, 0);

        // Held collision: 64 edges cover two blink periods -> 16 blanked slots
        colision = 1'b1;
        blanks = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (an == 4'b1111) blanks++;
        end
        check("blank_count", 8'(blanks), 8'd16);
        colision = 1'b0;
        check_digits(3, 7, 1, 0);

        // Reset during SHIFT
        score = 6'd50;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("midreset_busy", {7'b0, busy}, 8'h00);
        check("midreset_an", {4'b0, an}, 8'h0F);
        check("midreset_sseg", sseg, 8'hFF);
        score = 0;
        reset = 1'b1;
        @(negedge clk);
        check("post_reset_busy", {7'b0, busy}, 8'h00);
        check_digits(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
